// File: rtl/arith_unit_mc.sv
// Multi-cycle signed arithmetic unit: one-cycle ADD/SUB/MUL, iterative restoring DIV,
// with valid/ready handshakes on both the operand and the result side.
module arith_unit_mc #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           ALU_FUN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [2*WIDTH-1:0]   Arith_OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OVF,
  output logic                 DIV_ZERO,
  output logic                 dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // a source holds its payload stable until that edge, and ready never depends on
  // anything but state, OUT_VALID and OUT_READY.

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, next_state;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               neg_q, neg_r, div_ovf;

  logic               is_div, b_zero, accept, consume, start_div, last_iter;
  logic [2*WIDTH-1:0] a_ext, b_ext, fast_res;
  logic               fast_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   rem_n, quo_n, q_res, r_res;

  assign is_div    = (ALU_FUN == 2'b11);
  assign b_zero    = (B == '0);
  assign accept    = IN_VALID & IN_READY;
  assign consume   = OUT_VALID & OUT_READY;
  assign start_div = accept & is_div & ~b_zero;
  assign last_iter = (state == BUSY) && (cnt == '0);
  assign dbg_state = (state == BUSY);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    IN_READY   = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = ~OUT_VALID | OUT_READY;
        if (IN_VALID && (~OUT_VALID || OUT_READY) && is_div && !b_zero)
          next_state = BUSY;
      end
      BUSY: begin
        if (cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Single-cycle ops in 2*WIDTH bits are exact, so overflow is just a sign-extension test.
  assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};

  always_comb begin
    fast_res = '0;
    case (ALU_FUN)
      2'b00:   fast_res = a_ext + b_ext;
      2'b01:   fast_res = a_ext - b_ext;
      default: fast_res = a_ext * b_ext;
    endcase
  end

  assign fast_ovf = (fast_res != {{WIDTH{fast_res[WIDTH-1]}}, fast_res[WIDTH-1:0]});

  // Divider works on magnitudes; MIN's magnitude still fits WIDTH unsigned bits.
  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign rem_n   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_n   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign q_res   = neg_q ? -quo_n : quo_n;
  assign r_res   = neg_r ? -rem_n : rem_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_ovf   <= 1'b0;
      Arith_OUT <= '0;
      OUT_VALID <= 1'b0;
      OVF       <= 1'b0;
      DIV_ZERO  <= 1'b0;
    end else begin
      if (state == BUSY) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (start_div) begin
        rem_q   <= '0;
        quo_q   <= a_mag;
        dvs_q   <= b_mag;
        neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
        neg_r   <= A[WIDTH-1];
        div_ovf <= (A == MIN_VAL) && (B == '1);
        cnt     <= CW'(WIDTH - 1);
      end

      if (accept && !start_div) begin
        OUT_VALID <= 1'b1;
        if (is_div) begin
          Arith_OUT <= {A, {WIDTH{1'b0}}};
          OVF       <= 1'b0;
          DIV_ZERO  <= 1'b1;
        end else begin
          Arith_OUT <= fast_res;
          OVF       <= fast_ovf;
          DIV_ZERO  <= 1'b0;
        end
      end else if (last_iter) begin
        OUT_VALID <= 1'b1;
        Arith_OUT <= {r_res, q_res};
        OVF       <= div_ovf;
        DIV_ZERO  <= 1'b0;
      end else if (consume) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_mc.sv
// Bench for arith_unit_mc: directed scenarios plus a randomized handshake run,
// all checked against a plain-arithmetic reference model.
module tb_arith_unit_mc;

  localparam int W = 16;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [1:0]     ALU_FUN = 2'b00;
  logic           IN_VALID = 1'b0;
  logic           IN_READY;
  logic [2*W-1:0] Arith_OUT;
  logic           OUT_VALID;
  logic           OUT_READY = 1'b0;
  logic           OVF;
  logic           DIV_ZERO;
  logic           dbg_state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_check = 0;

  logic [2*W+1:0] exp_q[$];

  arith_unit_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Arith_OUT(Arith_OUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OVF(OVF),
    .DIV_ZERO(DIV_ZERO), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: returns {OVF, DIV_ZERO, Arith_OUT}.
  function automatic logic [2*W+1:0] model(input logic [1:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa  = longint'($signed(a));
    longint sb  = longint'($signed(b));
    longint lim = longint'(1) << (W - 1);
    longint r   = 0;
    longint q   = 0;
    longint rm  = 0;
    logic [2*W-1:0] o = '0;
    logic ovf = 1'b0;
    logic dz  = 1'b0;
    if (f != 2'b11) begin
      if (f == 2'b00)      r = sa + sb;
      else if (f == 2'b01) r = sa - sb;
      else                 r = sa * sb;
      o   = r[2*W-1:0];
      ovf = (r < -lim) || (r > lim - 1);
    end else if (sb == 0) begin
      o  = {a, {W{1'b0}}};
      dz = 1'b1;
    end else begin
      if (sa == -lim && sb == -1) begin
        q   = -lim;
        rm  = 0;
        ovf = 1'b1;
      end else begin
        q  = sa / sb;
        rm = sa % sb;
      end
      o = {rm[W-1:0], q[W-1:0]};
    end
    return {ovf, dz, o};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = {1'b1, {(W-1){1'b0}}};
      1:       v = {1'b0, {(W-1){1'b1}}};
      2:       v = '1;
      3:       v = '0;
      4:       v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // driver: issue one op with OUT_READY held high, measure latency and result
  task automatic run_op(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, output logic [2*W-1:0] got);
    logic [2*W+1:0] e;
    int lat, k, low;
    e   = model(f, a, b);
    lat = (f == 2'b11 && b != '0) ? W + 1 : 1;
    A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1;
    check({tag, " in_ready"}, IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    k   = 1;
    low = 0;
    while (!OUT_VALID && k < 3 * W) begin
      if (!IN_READY) low++;
      tick();
      k++;
    end
    check({tag, " latency"}, k, lat);
    check({tag, " ready_low"}, low, lat - 1);
    check({tag, " result"}, {OVF, DIV_ZERO, Arith_OUT}, e);
    got = Arith_OUT;
  endtask

  initial begin
    logic [2*W-1:0] got;
    logic           accepted, prev_stall;
    logic [2*W+1:0] prev_snap;
    int             seen;

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("reset out", {OUT_VALID, OVF, DIV_ZERO, Arith_OUT}, 0);
    RST = 1'b1;
    tick();
    check("reset in_ready", IN_READY, 1);
    check("reset idle outputs", {OUT_VALID, OVF, DIV_ZERO, Arith_OUT}, 0);

    // directed examples
    run_op(2'b00, 16'sd32767, 16'sd1, "add max+1", got);
    check("add max+1 const", got, 32'h0000_8000);
    run_op(2'b10, -16'sd300, 16'sd200, "mul", got);
    check("mul const", got, 32'hFFFF_15A0);
    run_op(2'b11, -16'sd7, 16'sd2, "div -7/2", got);
    check("div -7/2 const", got, 32'hFFFF_FFFD);
    run_op(2'b11, 16'h8000, 16'hFFFF, "div min/-1", got);
    check("div min/-1 const", got, 32'h0000_8000);
    run_op(2'b11, 16'sd5, 16'sd0, "div by zero", got);
    check("div by zero const", got, 32'h0005_0000);

    // back-to-back single-cycle ops
    A = 16'd1; B = 16'd1; ALU_FUN = 2'b00; IN_VALID = 1'b1; OUT_READY = 1'b1;
    tick();
    check("b2b first", {OUT_VALID, OVF, Arith_OUT}, {2'b10, 32'd2});
    A = 16'd2; B = 16'd5; ALU_FUN = 2'b01;
    #1;
    check("b2b in_ready", IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    check("b2b second", {OUT_VALID, OVF, Arith_OUT}, {2'b10, 32'hFFFF_FFFD});
    tick();

    // stall with a pending op, then release
    OUT_READY = 1'b0;
    A = 16'd10; B = 16'd3; ALU_FUN = 2'b01; IN_VALID = 1'b1;
    #1;
    check("stall accept ready", IN_READY, 1);
    tick();
    A = 16'd4; B = 16'd5; ALU_FUN = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall hold", {OUT_VALID, IN_READY, Arith_OUT}, {2'b10, 32'd7});
      tick();
    end
    OUT_READY = 1'b1;
    #1;
    check("release in_ready", IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    check("release result", {OUT_VALID, Arith_OUT}, {1'b1, 32'd9});
    tick();

    // async reset mid-divide
    A = 16'd100; B = 16'd3; ALU_FUN = 2'b11; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (4) tick();
    #2;
    RST = 1'b0;
    #1;
    check("abort outputs", {OUT_VALID, OVF, DIV_ZERO, Arith_OUT}, 0);
    check("abort in_ready", IN_READY, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (OUT_VALID) seen++;
    end
    check("abort no result", seen, 0);
    run_op(2'b11, 16'd100, 16'd3, "div after reset", got);
    check("div after reset const", got, 32'h0001_0021);
    tick();

    // randomized handshake run with scoreboard
    prev_stall = 1'b0;
    prev_snap  = '0;
    for (int c = 0; c < 600; c++) begin
      if (!IN_VALID && $urandom_range(0, 2) != 0) begin
        ALU_FUN  = 2'($urandom_range(0, 3));
        A        = pick();
        B        = pick();
        IN_VALID = 1'b1;
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall)
        check("rand hold", {OUT_VALID, OVF, DIV_ZERO, Arith_OUT}, {1'b1, prev_snap});
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) check("rand spurious", 1, 0);
        else check("rand result", {OVF, DIV_ZERO, Arith_OUT}, exp_q.pop_front());
      end
      accepted = IN_VALID && IN_READY;
      if (accepted) exp_q.push_back(model(ALU_FUN, A, B));
      prev_stall = OUT_VALID && !OUT_READY;
      prev_snap  = {OVF, DIV_ZERO, Arith_OUT};
      tick();
      if (accepted) IN_VALID = 1'b0;
    end

    // drain
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    for (int c = 0; c < 3 * W && exp_q.size() != 0; c++) begin
      #1;
      if (OUT_VALID) check("drain result", {OVF, DIV_ZERO, Arith_OUT}, exp_q.pop_front());
      tick();
    end
    check("drain empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
